// File: rtl/flash_reader_pkg.sv
// Shared constants for the SPI NOR flash read engine.
// Command byte, frame geometry and FSM state encodings.
package flash_reader_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int FRAME_BITS = 48;
  localparam int DATA_BITS = 16;

  localparam logic [1:0] ST_INIT_WAIT = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  function automatic logic [FRAME_BITS-1:0] read_frame(
    input logic [23:0] addr
  );
    return {FLASH_CMD_READ, addr, 16'h0000};
  endfunction

endpackage

// File: rtl/flash_reader_spi_shifter.sv
// SPI mode-0 bit engine: SCLK divider, 48-bit TX frame,
// 16-bit RX window and bit counter.
module flash_spi_shifter
  import flash_reader_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic                  miso_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_BITS-1:0]  rx_word_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]         div_q, div_d;
  logic                  sclk_q, sclk_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0]  rx_q, rx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
      tx_d   = frame_i;
      cnt_d  = CW'(FRAME_BITS);
    end else if (cnt_q != '0) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        // rising edge samples MISO, falling edge advances MOSI
        if (!sclk_q) begin
          rx_d = {rx_q[DATA_BITS-2:0], miso_i};
        end else begin
          tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
          cnt_d  = cnt_q - CW'(1);
          done_d = (cnt_q == CW'(1));
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[FRAME_BITS-1];
  assign busy_o    = (cnt_q != '0);
  assign done_o    = done_q;
  assign rx_word_o = rx_q;

endmodule

// File: rtl/flash_reader.sv
// SPI NOR flash READ engine serving 16-bit big-endian words
// to the CPU fetch path over an enable/ready handshake.
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int STARTUP_WAIT = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] flashReadAddr,
  input  logic        flashEnabled,
  output logic [15:0] flashByteRead,
  output logic        flashDataReady,
  output logic        flashClk,
  output logic        flashCs,
  output logic        flashMosi,
  input  logic        flashMiso
);

  localparam int IW = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
  localparam logic [IW-1:0] INIT_LAST =
    (STARTUP_WAIT > 1) ? IW'(STARTUP_WAIT - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] init_q, init_d;
  logic          cs_q, cs_d;
  logic          rdy_q, rdy_d;
  logic [15:0]   word_q, word_d;

  logic          start;
  logic          spi_busy;
  logic          spi_done;
  logic [15:0]   spi_word;

  assign start = (state_q == ST_IDLE) && flashEnabled && !spi_busy;

  flash_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_i     (reset),
    .start_i   (start),
    .frame_i   (read_frame(flashReadAddr)),
    .miso_i    (flashMiso),
    .sclk_o    (flashClk),
    .mosi_o    (flashMosi),
    .busy_o    (spi_busy),
    .done_o    (spi_done),
    .rx_word_o (spi_word)
  );

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    cs_d    = cs_q;
    rdy_d   = rdy_q;
    word_d  = word_q;
    unique case (state_q)
      ST_INIT_WAIT: begin
        if (STARTUP_WAIT <= 1 || init_q == INIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          init_d = init_q + IW'(1);
        end
      end
      ST_IDLE: begin
        if (start) begin
          cs_d    = 1'b0;
          rdy_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          cs_d    = 1'b1;
          rdy_d   = 1'b1;
          word_d  = spi_word;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // wait for the CPU to release the request first
        if (!flashEnabled) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT_WAIT;
      init_q  <= '0;
      cs_q    <= 1'b1;
      rdy_q   <= 1'b1;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      cs_q    <= cs_d;
      rdy_q   <= rdy_d;
      word_q  <= word_d;
    end
  end

  assign flashCs        = cs_q;
  assign flashDataReady = rdy_q;
  assign flashByteRead  = word_q;

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: behavioural SPI flash, address table,
// scoreboard queue and multi-cycle corner-case sequences.
module tb_flash_reader;

  localparam int CLK_DIV = 2;
  localparam int STARTUP_WAIT = 20;
  localparam int LAT = 1 + 96 * CLK_DIV;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] flashReadAddr = '0;
  logic        flashEnabled = 1'b0;
  logic [15:0] flashByteRead;
  logic        flashDataReady;
  logic        flashClk;
  logic        flashCs;
  logic        flashMosi;
  logic        flashMiso = 1'b0;

  flash_reader #(
    .CLK_DIV      (CLK_DIV),
    .STARTUP_WAIT (STARTUP_WAIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flashReadAddr  (flashReadAddr),
    .flashEnabled   (flashEnabled),
    .flashByteRead  (flashByteRead),
    .flashDataReady (flashDataReady),
    .flashClk       (flashClk),
    .flashCs        (flashCs),
    .flashMosi      (flashMosi),
    .flashMiso      (flashMiso)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fmem(input logic [23:0] a);
    case (a)
      24'h000000: return 8'h82;
      24'h000001: return 8'h01;
      24'h000002: return 8'h00;
      24'h000003: return 8'h05;
      24'h000010: return 8'hA5;
      24'h000011: return 8'hC3;
      default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // flash model: mode 0, header on rising edges, data on falling
  int          fbit = 0;
  logic [31:0] hdr_sh = '0;
  logic [31:0] hdr_cap = '0;
  logic [15:0] fword = '0;

  always @(posedge flashClk or negedge flashCs) begin
    if (flashClk) begin
      if (fbit < 32) hdr_sh = {hdr_sh[30:0], flashMosi};
      fbit = fbit + 1;
      if (fbit == 32) begin
        hdr_cap = hdr_sh;
        fword = {fmem(hdr_sh[23:0]), fmem(hdr_sh[23:0] + 24'd1)};
      end
    end else begin
      fbit = 0;
      hdr_sh = '0;
    end
  end

  always @(negedge flashClk) begin
    if (!flashCs && fbit >= 32 && fbit < 48)
      flashMiso = fword[15 - (fbit - 32)];
  end

  typedef struct {
    logic [23:0] addr;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] hdr;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] prev = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic request(input logic [23:0] a, input logic [15:0] w,
                         input bit push);
    exp_t e;
    flashEnabled = 1'b1;
    flashReadAddr = a;
    if (push) begin
      e.hdr = {8'h03, a};
      e.data = w;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_cs_low(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (flashCs && n < BUDGET);
    chk("cs_low", {31'd0, flashCs}, 32'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!flashDataReady && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("ready_rise", {31'd0, flashDataReady}, 32'd1);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("hdr", hdr_cap, e.hdr);
      chk("data", {16'd0, flashByteRead}, {16'd0, e.data});
      prev = e.data;
    end
  endtask

  task automatic finish_read();
    int m;
    wait_ready(m);
    chk("done_lat", m, LAT);
    chk("cs_idle", {31'd0, flashCs}, 32'd1);
    chk("sclk_idle", {31'd0, flashClk}, 32'd0);
    flashEnabled = 1'b0;
    pop_check();
  endtask

  task automatic do_read(input logic [23:0] a, input logic [15:0] w);
    int n;
    @(negedge clk);
    request(a, w, 1'b1);
    wait_cs_low(n);
    chk("accept_lat", n, 1);
    chk("rdy_fall", {31'd0, flashDataReady}, 32'd0);
    chk("mosi_msb", {31'd0, flashMosi}, 32'd0);
    chk("hold_prev", {16'd0, flashByteRead}, {16'd0, prev});
    finish_read();
  endtask

  task automatic startup_check();
    int n;
    bit ok;
    n = 0;
    ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (flashCs && !flashDataReady) ok = 1'b0;
    end while (flashCs && n < BUDGET);
    chk("startup_len", n, STARTUP_WAIT + 1);
    chk("startup_rdy", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int n;
    int lows;
    bit held;

    tbl[0] = '{24'h000010, 16'hA5C3};
    tbl[1] = '{24'h000000, 16'h8201};
    tbl[2] = '{24'h000002, 16'h0005};
    tbl[3] = '{24'h000123, 16'h787F};
    tbl[4] = '{24'h00AB00, 16'hF1F0};
    tbl[5] = '{24'hFFFFFF, 16'h5A82};

    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, flashDataReady}, 32'd1);
    chk("rst_cs", {31'd0, flashCs}, 32'd1);
    chk("rst_sclk", {31'd0, flashClk}, 32'd0);
    chk("rst_mosi", {31'd0, flashMosi}, 32'd0);
    chk("rst_word", {16'd0, flashByteRead}, 32'd0);

    // request held high across the power-up wait
    request(24'h000000, 16'h8201, 1'b1);
    reset = 1'b0;
    startup_check();
    finish_read();
    flashEnabled = 1'b1;
    held = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!flashCs || !flashDataReady) held = 1'b0;
    end
    chk("done_holds", {31'd0, held}, 32'd1);
    flashEnabled = 1'b0;

    foreach (tbl[i]) do_read(tbl[i].addr, tbl[i].exp);

    // CPU-style back-to-back with a two-cycle gap
    do_read(24'h000000, 16'h8201);
    held = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (!flashCs) held = 1'b0;
    end
    chk("gap_cs_high", {31'd0, held}, 32'd1);
    do_read(24'h000002, 16'h0005);

    // enable dropped mid-frame: must complete, no retrigger
    @(negedge clk);
    request(24'h000033, {fmem(24'h33), fmem(24'h34)}, 1'b1);
    wait_cs_low(n);
    repeat (20 * 2 * CLK_DIV) @(negedge clk);
    flashEnabled = 1'b0;
    wait_ready(n);
    pop_check();
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!flashCs) lows++;
    end
    chk("no_retrigger", lows, 0);

    // address changed one cycle after acceptance
    @(negedge clk);
    request(24'h000010, 16'hA5C3, 1'b1);
    wait_cs_low(n);
    flashReadAddr = 24'hFFFFFF;
    finish_read();

    // reset in the middle of a frame
    @(negedge clk);
    request(24'h000044, 16'h0000, 1'b0);
    wait_cs_low(n);
    repeat (30 * 2 * CLK_DIV) @(negedge clk);
    chk("mid_cs", {31'd0, flashCs}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_cs", {31'd0, flashCs}, 32'd1);
    chk("arst_sclk", {31'd0, flashClk}, 32'd0);
    chk("arst_rdy", {31'd0, flashDataReady}, 32'd1);
    chk("arst_word", {16'd0, flashByteRead}, 32'd0);
    prev = '0;
    flashEnabled = 1'b0;
    @(negedge clk);
    request(24'h000010, 16'hA5C3, 1'b1);
    reset = 1'b0;
    startup_check();
    finish_read();

    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
